// File: rtl/ltc5548_spi_responder_pkg.sv
// Shared constants and types for the LTC5548 SPI responder.
package ltc5548_pkg;

    localparam int FRAME_W      = 16;     // bits per frame
    localparam int RW_BIT       = 15;     // rw flag position within the frame
    localparam int FRAME_ADDR_W = 7;      // address field width
    localparam logic [7:0] CHIP_ID_DEF = 8'h48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ltc5548_spi_responder_if.sv
// SPI pin bundle between a master and the responder.
interface ltc5548_spi_responder_if;
    logic sclk;
    logic mosi;
    logic ss_n;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output mosi, output ss_n, input miso, input miso_oe);
    modport slave  (input sclk, input mosi, input ss_n, output miso, output miso_oe);
endinterface

// File: rtl/ltc5548_sync_edge.sv
// Two-flop synchronizer with single-cycle rise/fall pulses on the synced level.
module ltc5548_sync_edge #(
    parameter logic RST_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_LVL;
            sync_q <= RST_LVL;
            prev_q <= RST_LVL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;
    assign fall_o  = ~sync_q & prev_q;
endmodule

// File: rtl/ltc5548_spi_responder.sv
// SPI mode-0 responder modelling the LTC5548 register file: 16-bit frames
// {rw, addr[6:0], data[7:0]}, writes committed with a strobe, reads shifted out on MISO.
module ltc5548_spi_responder
    import ltc5548_pkg::*;
#(
    parameter int         NUM_REGS = 8,
    parameter int         ADDR_W   = FRAME_ADDR_W,
    parameter logic [7:0] CHIP_ID  = CHIP_ID_DEF,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    ltc5548_spi_responder_if.slave spi,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [7:0]            wr_data,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic                  frame_err
);
    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic ss_n_s, ss_rise, ss_fall;
    logic mosi_meta_q, mosi_s_q;

    state_t            state_q, state_d;
    logic [4:0]        bitcnt_q, bitcnt_d;
    logic [6:0]        rx_q, rx_d;
    logic [7:0]        rx_next;
    logic [7:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              frame_err_q, frame_err_d;
    logic [7:0]        regs_q [NUM_REGS];
    logic [7:0]        rd_data;

    ltc5548_sync_edge #(.RST_LVL(1'b0)) u_sclk_sync (
        .clk(clk_clk), .rst_n(reset_reset_n), .d_i(spi.sclk),
        .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    ltc5548_sync_edge #(.RST_LVL(1'b1)) u_ss_sync (
        .clk(clk_clk), .rst_n(reset_reset_n), .d_i(spi.ss_n),
        .level_o(ss_n_s), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    // MOSI shares the SCLK synchronizer latency so it lines up with the rise pulse
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mosi_meta_q <= 1'b0;
            mosi_s_q    <= 1'b0;
        end else begin
            mosi_meta_q <= spi.mosi;
            mosi_s_q    <= mosi_meta_q;
        end
    end

    assign rx_next = {rx_q, mosi_s_q};

    // Read-back mux: out-of-range addresses return zero
    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rx_next[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs_q[i];
        end
    end

    // Frame FSM next-state and output decode
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d  = CMD;
                    bitcnt_d = 5'd0;
                end
            end
            CMD: begin
                if (sclk_rise) begin
                    rx_d     = rx_next[6:0];
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (bitcnt_q == 5'd7) begin
                        rw_d    = rx_next[7];
                        addr_d  = rx_next[ADDR_W-1:0];
                        tx_d    = rx_next[7] ? rd_data : 8'h00;
                        state_d = DATA;
                    end
                end else if (sclk_fall) begin
                    miso_d = 1'b0;
                end
            end
            DATA: begin
                if (sclk_rise) begin
                    rx_d     = rx_next[6:0];
                    bitcnt_d = bitcnt_q + 5'd1;
                    if (bitcnt_q == 5'd15) begin
                        state_d = DONE;
                        miso_d  = 1'b0;
                        if (!rw_q) begin
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                            wr_data_d   = rx_next;
                        end
                    end
                end else if (sclk_fall) begin
                    if (rw_q) begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end else begin
                        miso_d = 1'b0;
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
            end
        endcase

        // Deselect wins over everything; a short frame is flagged and its write dropped
        if (state_q != IDLE && ss_rise) begin
            state_d     = IDLE;
            miso_d      = 1'b0;
            wr_strobe_d = 1'b0;
            wr_addr_d   = wr_addr_q;
            wr_data_d   = wr_data_q;
            frame_err_d = (bitcnt_q < 5'd16);
        end
    end

    // FSM and output registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= IDLE;
            bitcnt_q    <= 5'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'h00;
            miso_q      <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Register file: updated the cycle after the strobe; address 0 is the fixed chip ID
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            regs_q[0] <= CHIP_ID;
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_strobe_q && wr_addr_q == ADDR_W'(i)) regs_q[i] <= wr_data_q;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
        assign regs_flat[8*gi +: 8] = regs_q[gi];
    end

    assign spi.miso_oe = ~ss_n_s;
    assign spi.miso    = ~ss_n_s & miso_q;
    assign wr_strobe   = wr_strobe_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign frame_err   = frame_err_q;
endmodule
